data_mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the 64x16 data memory.
- Port 0 is the CPU load/store stage; port 1 is the debug/loader port.
- Serialises one access at a time with round-robin fairness, drives the memory's write-enable, read-enable, address and write-data, and returns registered read data with a one-cycle ack.
- Rejects out-of-range addresses without touching memory.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/data_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the two-port data memory arbiter.
package dmem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbStateT;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the port that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_valid
);
    import dmem_pkg::*;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = PORT_CPU;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (req[1]) begin
            gnt_idx = PORT_DBG;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises CPU and debug accesses to the 64x16 data memory, one
// transaction per three cycles (IDLE -> ACCESS -> DONE), with registered responses.
module data_mem_arbiter #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int DEPTH  = dmem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);
    import dmem_pkg::*;

    // One extra bit so the full address is compared against DEPTH without wrap.
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    function automatic logic inRange(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_V;
    endfunction

    arbStateT          state;
    logic              last_grant;
    logic              gnt_idx;
    logic              gnt_valid;
    logic              latWe;
    logic              latErr;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              selInRange;

    rr_arbiter2 uArb (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    always_comb begin
        selWe    = p0_we;
        selAddr  = p0_addr;
        selWdata = p0_wdata;
        if (gnt_idx == PORT_DBG) begin
            selWe    = p1_we;
            selAddr  = p1_addr;
            selWdata = p1_wdata;
        end
        selInRange = inRange(selAddr);
    end

    assign busy = (state != IDLE);

    // mem_addr/mem_wdata double as the latched request, so they naturally
    // hold their last value outside ACCESS; only the enables are pulsed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_DBG;
            grant_id   <= PORT_CPU;
            latWe      <= 1'b0;
            latErr     <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        latWe      <= selWe;
                        latErr     <= ~selInRange;
                        mem_addr   <= selAddr;
                        mem_wdata  <= selWdata;
                        mem_we     <= selWe & selInRange;
                        mem_re     <= ~selWe & selInRange;
                        grant_id   <= gnt_idx;
                        last_grant <= gnt_idx;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                    if (grant_id == PORT_CPU) begin
                        p0_ack <= 1'b1;
                        p0_err <= latErr;
                        if (!latWe && !latErr) begin
                            p0_rdata <= mem_rdata;
                        end
                    end else begin
                        p1_ack <= 1'b1;
                        p1_err <= latErr;
                        if (!latWe && !latErr) begin
                            p1_rdata <= mem_rdata;
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    p0_ack <= 1'b0;
                    p0_err <= 1'b0;
                    p1_ack <= 1'b0;
                    p1_err <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random two-port traffic
// checked every cycle against a transaction-level model with a shadow memory.
module tb_data_mem_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p0_err, p1_ack, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, grant_id;

    logic          reqV   [2];
    logic          weV    [2];
    logic [AW-1:0] addrV  [2];
    logic [DW-1:0] wdataV [2];

    assign p0_req = reqV[0];  assign p0_we = weV[0];
    assign p0_addr = addrV[0]; assign p0_wdata = wdataV[0];
    assign p1_req = reqV[1];  assign p1_we = weV[1];
    assign p1_addr = addrV[1]; assign p1_wdata = wdataV[1];

    data_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on negedge.
    logic [DW-1:0] memArr [DEPTH];
    always @(negedge clk) if (mem_we) memArr[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = memArr[mem_addr[5:0]];

    // Transaction-level model: cycles left in the current transaction
    // (0 = free, 2 = memory access cycle, 1 = response cycle).
    int            remaining;
    logic          mPort, mWe, mLast, mGrant;
    logic [AW-1:0] mAddr, eAddr;
    logic [DW-1:0] mWdata, eWdata;
    logic [DW-1:0] mRdata [2];
    logic [DW-1:0] golden [DEPTH];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        remaining = 0;
        mLast = 1'b1; mGrant = 1'b0; mPort = 1'b0; mWe = 1'b0;
        mAddr = '0; mWdata = '0; eAddr = '0; eWdata = '0;
        mRdata[0] = '0; mRdata[1] = '0;
    endtask

    task automatic modelStep();
        logic p;
        if (remaining == 0) begin
            if (reqV[0] || reqV[1]) begin
                p = (reqV[0] && reqV[1]) ? ~mLast : (reqV[0] ? 1'b0 : 1'b1);
                mPort = p; mWe = weV[p]; mAddr = addrV[p]; mWdata = wdataV[p];
                mLast = p; mGrant = p; eAddr = mAddr; eWdata = mWdata;
                remaining = 2;
            end
        end else if (remaining == 2) begin
            if (mAddr < DEPTH) begin
                if (mWe) golden[mAddr[5:0]] = mWdata;
                else     mRdata[mPort] = golden[mAddr[5:0]];
            end
            remaining = 1;
        end else begin
            remaining = 0;
        end
    endtask

    task automatic checkAll();
        logic acc, inR, ack0, ack1;
        acc  = (remaining == 2);
        inR  = (mAddr < DEPTH);
        ack0 = (remaining == 1) && (mPort == 1'b0);
        ack1 = (remaining == 1) && (mPort == 1'b1);
        chk("mem_we",    32'(mem_we),    32'(acc && mWe && inR));
        chk("mem_re",    32'(mem_re),    32'(acc && !mWe && inR));
        chk("mem_addr",  32'(mem_addr),  32'(eAddr));
        chk("mem_wdata", 32'(mem_wdata), 32'(eWdata));
        chk("busy",      32'(busy),      32'(remaining != 0));
        chk("grant_id",  32'(grant_id),  32'(mGrant));
        chk("p0_ack",    32'(p0_ack),    32'(ack0));
        chk("p1_ack",    32'(p1_ack),    32'(ack1));
        chk("p0_err",    32'(p0_err),    32'(ack0 && !inR));
        chk("p1_err",    32'(p1_err),    32'(ack1 && !inR));
        chk("p0_rdata",  32'(p0_rdata),  32'(mRdata[0]));
        chk("p1_rdata",  32'(p1_rdata),  32'(mRdata[1]));
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic setPort(input int p, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        reqV[p] = r; weV[p] = w; addrV[p] = a; wdataV[p] = d;
    endtask

    task automatic newReq(input int p);
        logic [AW-1:0] a;
        case ($urandom_range(0, 3))
            0:       a = 8'($urandom_range(64, 255));
            1:       a = 8'($urandom_range(0, 63));
            default: a = 8'($urandom_range(0, 7));
        endcase
        setPort(p, 1'b1, 1'($urandom_range(0, 1)), a, 16'($urandom));
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        setPort(0, 1'b0, 1'b0, '0, '0);
        setPort(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ackPort[$];
        int ackCyc[$];
        int expOrder [4];

        reset = 1'b1;
        setPort(0, 1'b0, 1'b0, '0, '0);
        setPort(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            memArr[i] = '0;
            golden[i] = '0;
        end
        modelReset();
        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_grant",  32'(grant_id), 32'd0);
        chk("rst_mem_we", 32'(mem_we),   32'd0);
        chk("rst_mem_re", 32'(mem_re),   32'd0);
        chk("rst_p0_ack", 32'(p0_ack),   32'd0);
        chk("rst_p1_ack", 32'(p1_ack),   32'd0);
        chk("rst_p0_rd",  32'(p0_rdata), 32'd0);
        reset = 1'b0;

        // Port 0 writes 0x1234 to 0x02.
        setPort(0, 1'b1, 1'b1, 8'h02, 16'h1234);
        tick();
        chk("t1_mem_we", 32'(mem_we), 32'd1);
        chk("t1_addr",   32'(mem_addr), 32'h02);
        tick();
        chk("t1_ack",    32'(p0_ack), 32'd1);
        chk("t1_err",    32'(p0_err), 32'd0);
        chk("t1_we_off", 32'(mem_we), 32'd0);
        setPort(0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("t1_mem", 32'(memArr[2]), 32'h1234);

        // Port 1 reads it back.
        setPort(1, 1'b1, 1'b0, 8'h02, '0);
        tick();
        chk("t2_mem_re", 32'(mem_re), 32'd1);
        tick();
        chk("t2_ack",   32'(p1_ack),   32'd1);
        chk("t2_rdata", 32'(p1_rdata), 32'h1234);
        chk("t2_p0ack", 32'(p0_ack),   32'd0);
        setPort(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Both ports read continuously from reset.
        doReset();
        setPort(0, 1'b1, 1'b0, 8'h02, '0);
        setPort(1, 1'b1, 1'b0, 8'h03, '0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (p0_ack) begin ackPort.push_back(0); ackCyc.push_back(i); end
            if (p1_ack) begin ackPort.push_back(1); ackCyc.push_back(i); end
        end
        expOrder = '{0, 1, 0, 1};
        chk("t3_nacks", 32'(ackPort.size()), 32'd4);
        for (int i = 0; i < 4 && i < ackPort.size(); i++) begin
            chk("t3_order", 32'(ackPort[i]), 32'(expOrder[i]));
            if (i > 0) chk("t3_spacing", 32'(ackCyc[i] - ackCyc[i-1]), 32'd3);
        end
        setPort(0, 1'b0, 1'b0, '0, '0);
        setPort(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Out-of-range write to 0x40 must not wrap onto 0x00.
        setPort(0, 1'b1, 1'b1, 8'h40, 16'hFFFF);
        tick();
        chk("t4_mem_we", 32'(mem_we), 32'd0);
        chk("t4_mem_re", 32'(mem_re), 32'd0);
        tick();
        chk("t4_ack", 32'(p0_ack), 32'd1);
        chk("t4_err", 32'(p0_err), 32'd1);
        setPort(0, 1'b1, 1'b0, 8'h00, '0);
        repeat (3) tick();
        chk("t4_rd_ack", 32'(p0_ack),   32'd1);
        chk("t4_rd_val", 32'(p0_rdata), 32'h0000);
        setPort(0, 1'b0, 1'b0, '0, '0);
        tick();

        // Reset asserted in the middle of an ACCESS write.
        setPort(0, 1'b1, 1'b1, 8'h05, 16'hBEEF);
        modelStep();
        @(posedge clk);
        #2;
        chk("t5_we_before", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_we_dropped", 32'(mem_we), 32'd0);
        chk("t5_busy_rst",   32'(busy),   32'd0);
        setPort(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_no_ack", 32'(p0_ack), 32'd0);
        reset = 1'b0;
        modelReset();
        chk("t5_busy",  32'(busy),       32'd0);
        chk("t5_grant", 32'(grant_id),   32'd0);
        chk("t5_mem",   32'(memArr[5]),  32'h0000);

        // Both request after reset: port 0 first, port 1 follows its DONE.
        setPort(0, 1'b1, 1'b0, 8'h05, '0);
        setPort(1, 1'b1, 1'b0, 8'h02, '0);
        tick();
        chk("t6_first_grant", 32'(grant_id), 32'd0);
        tick();
        chk("t6_p0_ack",   32'(p0_ack),   32'd1);
        chk("t6_p0_rdata", 32'(p0_rdata), 32'h0000);
        setPort(0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        chk("t6_p1_grant", 32'(grant_id), 32'd1);
        tick();
        chk("t6_p1_ack",   32'(p1_ack),   32'd1);
        chk("t6_p1_rdata", 32'(p1_rdata), 32'h1234);
        setPort(1, 1'b0, 1'b0, '0, '0);
        tick();

        // Random traffic on both ports.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (reqV[p]) begin
                    if (remaining == 1 && mPort == 1'(p)) begin
                        if ($urandom_range(0, 1) == 0) setPort(p, 1'b0, 1'b0, '0, '0);
                        else newReq(p);
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    newReq(p);
                end
            end
            tick();
        end
        setPort(0, 1'b0, 1'b0, '0, '0);
        setPort(1, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
